// File: rtl/sd_card_responder.sv
// SPI-mode SD card model: decodes 48-bit commands, answers R1/R2/R7, serves block reads and writes
// through an external byte-wide synchronous memory. Define SD_RESPONDER_CRC_EN to check command CRC7.
`timescale 1ns/1ps
module sd_card_responder #(
  parameter int NUM_BLOCKS     = 1024,
  parameter int ACMD41_RETRIES = 2,
  parameter int BUSY_BYTES     = 4,
  localparam int BLK_W  = $clog2(NUM_BLOCKS),
  localparam int ADDR_W = BLK_W + 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              card_ready,
  output logic              busy
);

  typedef enum logic [3:0] {
    RX_CMD, NCR, TX_RESP, TX_NAC, TX_TOKEN, TX_DATA, TX_CRC,
    RX_WAIT_TOKEN, RX_DATA, RX_CRC, TX_DATA_RESP, TX_BUSY
  } state_t;

  typedef enum logic [1:0] {ACT_NONE, ACT_READ, ACT_WRITE} act_t;

  state_t state, state_next;

  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_prev;
  logic       cs_active, sck_rise, sck_fall, mosi_s;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift, tx_load, tx_next;

  logic [2:0]       cmd_cnt;
  logic [5:0]       cmd_idx;
  logic [31:0]      cmd_arg;
  logic [39:0]      resp_buf;
  logic [2:0]       resp_left;
  act_t             act_reg;
  logic [BLK_W-1:0] blk_reg;
  logic             ready_pend, app_flag;
  logic [7:0]       acmd_cnt;
  logic [9:0]       cnt;

  logic [39:0] ev_resp;
  logic [2:0]  ev_len;
  act_t        ev_act;
  logic        ev_app, ev_clear, ev_acmd_inc, ev_ready_pend;
  logic        crc_bad;
  logic [7:0]  idle_r1;

  assign idle_r1 = {7'b0, ~card_ready};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_prev  <= sck_sync[1];
    end
  end

  assign cs_active = ~cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sck_rise  = cs_active & sck_sync[1] & ~sck_prev;
  assign sck_fall  = cs_active & ~sck_sync[1] & sck_prev;
  assign rx_done   = sck_rise & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi_s};

`ifdef SD_RESPONDER_CRC_EN
  logic [6:0] crc_reg;
  logic       crc_chk_en;

  function automatic logic [6:0] crc7_byte(input logic [6:0] c_in, input logic [7:0] d);
    logic [6:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // CMD0 and CMD8 are always checked so a host can never lose the reset path.
  assign crc_bad = (crc_chk_en || cmd_idx == 6'd0 || cmd_idx == 6'd8) && (rx_byte[7:1] != crc_reg);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    ev_resp       = {8'h04 | idle_r1, 32'hFFFF_FFFF};
    ev_len        = 3'd0;
    ev_act        = ACT_NONE;
    ev_app        = 1'b0;
    ev_clear      = 1'b0;
    ev_acmd_inc   = 1'b0;
    ev_ready_pend = 1'b0;
    case (cmd_idx)
      6'd0: begin
        ev_resp  = {8'h01, 32'hFFFF_FFFF};
        ev_clear = 1'b1;
      end
      6'd8: begin
        ev_resp = {idle_r1, 8'h00, 8'h00, 8'h01, cmd_arg[7:0]};
        ev_len  = 3'd4;
      end
      6'd59: ev_resp = {idle_r1, 32'hFFFF_FFFF};
      6'd55: begin
        ev_resp = {idle_r1, 32'hFFFF_FFFF};
        ev_app  = 1'b1;
      end
      6'd41: begin
        if (app_flag) begin
          if (card_ready) begin
            ev_resp = {8'h00, 32'hFFFF_FFFF};
          end else if (acmd_cnt < 8'(ACMD41_RETRIES)) begin
            ev_resp     = {8'h01, 32'hFFFF_FFFF};
            ev_acmd_inc = 1'b1;
          end else begin
            ev_resp       = {8'h00, 32'hFFFF_FFFF};
            ev_ready_pend = 1'b1;
          end
        end
      end
      6'd16: begin
        if (!card_ready)              ev_resp = {8'h05, 32'hFFFF_FFFF};
        else if (cmd_arg == 32'd512)  ev_resp = {8'h00, 32'hFFFF_FFFF};
        else                          ev_resp = {8'h40, 32'hFFFF_FFFF};
      end
      6'd13: begin
        if (!card_ready) begin
          ev_resp = {8'h05, 32'hFFFF_FFFF};
        end else begin
          ev_resp = {8'h00, 8'h00, 24'hFF_FFFF};
          ev_len  = 3'd1;
        end
      end
      6'd17, 6'd24: begin
        if (!card_ready) begin
          ev_resp = {8'h05, 32'hFFFF_FFFF};
        end else if (cmd_arg >= 32'(NUM_BLOCKS)) begin
          ev_resp = {8'h40, 32'hFFFF_FFFF};
        end else begin
          ev_resp = {8'h00, 32'hFFFF_FFFF};
          ev_act  = (cmd_idx == 6'd17) ? ACT_READ : ACT_WRITE;
        end
      end
      default: ;
    endcase
    if (crc_bad) begin
      ev_resp       = {8'h08 | idle_r1, 32'hFFFF_FFFF};
      ev_len        = 3'd0;
      ev_act        = ACT_NONE;
      ev_app        = 1'b0;
      ev_clear      = 1'b0;
      ev_acmd_inc   = 1'b0;
      ev_ready_pend = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RX_CMD;
    else       state <= state_next;
  end

  // Decisions are made at the end of each received byte; tx_next is the byte for the following slot.
  always_comb begin
    state_next = state;
    tx_next    = 8'hFF;
    if (!cs_active) begin
      state_next = RX_CMD;
    end else if (rx_done) begin
      case (state)
        RX_CMD:  if (cmd_cnt == 3'd5) state_next = NCR;
        NCR: begin
          state_next = TX_RESP;
          tx_next    = resp_buf[39:32];
        end
        TX_RESP: begin
          if (resp_left != 3'd0)       tx_next = resp_buf[39:32];
          else if (act_reg == ACT_READ)  state_next = TX_NAC;
          else if (act_reg == ACT_WRITE) state_next = RX_WAIT_TOKEN;
          else                           state_next = RX_CMD;
        end
        TX_NAC: begin
          state_next = TX_TOKEN;
          tx_next    = 8'hFE;
        end
        TX_TOKEN: begin
          state_next = TX_DATA;
          tx_next    = mem_rd_data;
        end
        TX_DATA: begin
          if (cnt == 10'd511) state_next = TX_CRC;
          else                tx_next    = mem_rd_data;
        end
        TX_CRC:  if (cnt == 10'd1) state_next = RX_CMD;
        RX_WAIT_TOKEN: begin
          if (rx_byte == 8'hFE)      state_next = RX_DATA;
          else if (rx_byte != 8'hFF) state_next = RX_CMD;
        end
        RX_DATA: if (cnt == 10'd511) state_next = RX_CRC;
        RX_CRC: begin
          if (cnt == 10'd1) begin
            state_next = TX_DATA_RESP;
            tx_next    = 8'h05;
          end
        end
        TX_DATA_RESP: begin
          if (BUSY_BYTES == 0) begin
            state_next = RX_CMD;
          end else begin
            state_next = TX_BUSY;
            tx_next    = 8'h00;
          end
        end
        TX_BUSY: begin
          if (cnt == 10'(BUSY_BYTES - 1)) state_next = RX_CMD;
          else                            tx_next    = 8'h00;
        end
        default: state_next = RX_CMD;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'hFF;
      tx_load     <= 8'hFF;
      miso        <= 1'b1;
      cmd_cnt     <= 3'd0;
      cmd_idx     <= 6'd0;
      cmd_arg     <= 32'd0;
      resp_buf    <= 40'hFF_FFFF_FFFF;
      resp_left   <= 3'd0;
      act_reg     <= ACT_NONE;
      blk_reg     <= '0;
      ready_pend  <= 1'b0;
      app_flag    <= 1'b0;
      acmd_cnt    <= 8'd0;
      card_ready  <= 1'b0;
      busy        <= 1'b0;
      cnt         <= 10'd0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'd0;
`ifdef SD_RESPONDER_CRC_EN
      crc_reg     <= 7'd0;
      crc_chk_en  <= 1'b1;
`endif
    end else begin
      mem_wr_en <= 1'b0;
      if (!cs_active) begin
        bit_cnt    <= 3'd0;
        tx_shift   <= 8'hFF;
        tx_load    <= 8'hFF;
        miso       <= 1'b1;
        cmd_cnt    <= 3'd0;
        ready_pend <= 1'b0;
        busy       <= 1'b0;
        cnt        <= 10'd0;
      end else begin
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (sck_fall) begin
          if (bit_cnt == 3'd0) begin
            tx_shift <= tx_load;
            miso     <= tx_load[7];
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b1};
            miso     <= tx_shift[6];
          end
        end
        if (rx_done) begin
          tx_load <= tx_next;
          case (state)
            RX_CMD: begin
              if (cmd_cnt == 3'd0) begin
                if (rx_byte[7:6] == 2'b01) begin
                  cmd_idx <= rx_byte[5:0];
                  cmd_cnt <= 3'd1;
`ifdef SD_RESPONDER_CRC_EN
                  crc_reg <= crc7_byte(7'd0, rx_byte);
`endif
                end
              end else if (cmd_cnt != 3'd5) begin
                cmd_arg <= {cmd_arg[23:0], rx_byte};
                cmd_cnt <= cmd_cnt + 3'd1;
`ifdef SD_RESPONDER_CRC_EN
                crc_reg <= crc7_byte(crc_reg, rx_byte);
`endif
              end else begin
                cmd_cnt    <= 3'd0;
                resp_buf   <= ev_resp;
                resp_left  <= ev_len;
                act_reg    <= ev_act;
                blk_reg    <= cmd_arg[BLK_W-1:0];
                app_flag   <= ev_app;
                ready_pend <= ev_ready_pend;
                if (ev_clear) begin
                  card_ready <= 1'b0;
                  acmd_cnt   <= 8'd0;
                end
                if (ev_acmd_inc) acmd_cnt <= acmd_cnt + 8'd1;
`ifdef SD_RESPONDER_CRC_EN
                if (cmd_idx == 6'd59 && !crc_bad) crc_chk_en <= cmd_arg[0];
`endif
              end
            end
            NCR: resp_buf <= {resp_buf[31:0], 8'hFF};
            TX_RESP: begin
              if (resp_left != 3'd0) begin
                resp_buf  <= {resp_buf[31:0], 8'hFF};
                resp_left <= resp_left - 3'd1;
              end else begin
                if (ready_pend) card_ready <= 1'b1;
                ready_pend <= 1'b0;
                cnt        <= 10'd0;
                if (act_reg == ACT_READ) mem_addr <= {blk_reg, 9'd0};
              end
            end
            // Address for the byte after next goes out here, well ahead of its load.
            TX_TOKEN: begin
              mem_addr <= {blk_reg, 9'd1};
              cnt      <= 10'd0;
            end
            TX_DATA: begin
              mem_addr <= {blk_reg, 9'(cnt + 10'd2)};
              cnt      <= (cnt == 10'd511) ? 10'd0 : cnt + 10'd1;
            end
            TX_CRC, RX_CRC: cnt <= (cnt == 10'd1) ? 10'd0 : cnt + 10'd1;
            RX_WAIT_TOKEN: begin
              if (rx_byte == 8'hFE) begin
                busy <= 1'b1;
                cnt  <= 10'd0;
              end
            end
            RX_DATA: begin
              mem_wr_en   <= 1'b1;
              mem_addr    <= {blk_reg, cnt[8:0]};
              mem_wr_data <= rx_byte;
              cnt         <= (cnt == 10'd511) ? 10'd0 : cnt + 10'd1;
            end
            TX_DATA_RESP: begin
              cnt <= 10'd0;
              if (BUSY_BYTES == 0) busy <= 1'b0;
            end
            TX_BUSY: begin
              if (cnt == 10'(BUSY_BYTES - 1)) begin
                busy <= 1'b0;
                cnt  <= 10'd0;
              end else begin
                cnt <= cnt + 10'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_card_responder.sv
// Bench for sd_card_responder: command table plus write/read, abort and bad-token sequences.
`timescale 1ns/1ps
module tb_sd_card_responder;
  localparam int NB = 16;
  localparam int AW = $clog2(NB) + 9;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sck = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b1;
  logic          miso;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic          card_ready;
  logic          busy;

  sd_card_responder #(.NUM_BLOCKS(NB), .ACMD41_RETRIES(2), .BUSY_BYTES(4)) dut (
    .clock(clock), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .card_ready(card_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [NB*512];
  int   wr_pulses = 0;
  logic wr_prev = 1'b0;
  logic wr_double = 1'b0;

  always @(posedge clock) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (mem_wr_en) wr_pulses <= wr_pulses + 1;
    wr_prev <= mem_wr_en;
    if (mem_wr_en && wr_prev) wr_double <= 1'b1;
  end

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ m[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #30;
      rx[i] = miso;
      sck = 1'b1;
      #30;
      sck = 1'b0;
    end
  endtask

  task automatic send_raw(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc_byte);
    logic [47:0] f;
    logic [7:0]  d;
    f = {2'b01, idx, arg, crc_byte};
    for (int k = 5; k >= 0; k--) xfer(f[8*k +: 8], d);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
    send_raw(idx, arg, {crc7({2'b01, idx, arg}), 1'b1});
  endtask

  task automatic expect_bytes(input int n, input string tag);
    logic [7:0] b, e;
    for (int k = 0; k < n; k++) begin
      xfer(8'hFF, b);
      if (sb.size() == 0) begin
        check($sformatf("%s_sb_empty", tag), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s[%0d]", tag, k), {24'd0, b}, {24'd0, e});
      end
    end
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          nresp;
    logic [39:0] resp;
    logic        ready;
  } vec_t;

  vec_t vt[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] r;
    logic [7:0]  d;
    int          errs, wr_snap;

    vt[0]  = '{6'd0,  32'h0,        1, 40'h01_0000_0000, 1'b0};
    vt[1]  = '{6'd17, 32'h0,        1, 40'h05_0000_0000, 1'b0};
    vt[2]  = '{6'd8,  32'h1AA,      5, 40'h01_0000_01AA, 1'b0};
    vt[3]  = '{6'd59, 32'h0,        1, 40'h01_0000_0000, 1'b0};
    vt[4]  = '{6'd41, 32'h4000_0000,1, 40'h05_0000_0000, 1'b0};
    vt[5]  = '{6'd55, 32'h0,        1, 40'h01_0000_0000, 1'b0};
    vt[6]  = '{6'd41, 32'h4000_0000,1, 40'h01_0000_0000, 1'b0};
    vt[7]  = '{6'd55, 32'h0,        1, 40'h01_0000_0000, 1'b0};
    vt[8]  = '{6'd41, 32'h4000_0000,1, 40'h01_0000_0000, 1'b0};
    vt[9]  = '{6'd55, 32'h0,        1, 40'h01_0000_0000, 1'b0};
    vt[10] = '{6'd41, 32'h4000_0000,1, 40'h00_0000_0000, 1'b1};
    vt[11] = '{6'd16, 32'd512,      1, 40'h00_0000_0000, 1'b1};
    vt[12] = '{6'd16, 32'd1024,     1, 40'h40_0000_0000, 1'b1};
    vt[13] = '{6'd13, 32'h0,        2, 40'h00_0000_0000, 1'b1};
    vt[14] = '{6'd17, NB,           1, 40'h40_0000_0000, 1'b1};
    vt[15] = '{6'd24, NB,           1, 40'h40_0000_0000, 1'b1};
    vt[16] = '{6'd2,  32'h0,        1, 40'h04_0000_0000, 1'b1};

    #53 reset = 1'b0;
    #50;
    check("rst_miso", {31'd0, miso}, 32'd1);
    check("rst_addr", {{(32-AW){1'b0}}, mem_addr}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    check("rst_ready", {31'd0, card_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    cs_n = 1'b0;
    #100;

`ifdef SD_RESPONDER_CRC_EN
    send_raw(6'd0, 32'h0, 8'h00);
    sb.push_back(8'hFF); sb.push_back(8'h09); sb.push_back(8'hFF);
    expect_bytes(3, "crc_bad");
    send_raw(6'd0, 32'h0, 8'h95);
    sb.push_back(8'hFF); sb.push_back(8'h01); sb.push_back(8'hFF);
    expect_bytes(3, "crc_ok");
`endif

    for (int v = 0; v < 17; v++) begin
      send_cmd(vt[v].idx, vt[v].arg);
      sb.push_back(8'hFF);
      r = vt[v].resp;
      for (int k = 0; k < vt[v].nresp; k++) sb.push_back(r[39-8*k -: 8]);
      sb.push_back(8'hFF);
      expect_bytes(vt[v].nresp + 2, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_ready", v), {31'd0, card_ready}, {31'd0, vt[v].ready});
    end

    // Block write of i^0xA5 to block 5
    send_cmd(6'd24, 32'd5);
    sb.push_back(8'hFF); sb.push_back(8'h00);
    expect_bytes(2, "wr_r1");
    xfer(8'hFF, d);
    check("wr_busy_pre", {31'd0, busy}, 32'd0);
    xfer(8'hFE, d);
    check("wr_busy_tok", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 512; i++) xfer(8'(i) ^ 8'hA5, d);
    xfer(8'hFF, d);
    xfer(8'hFF, d);
    check("wr_busy_crc", {31'd0, busy}, 32'd1);
    sb.push_back(8'h05);
    for (int i = 0; i < 4; i++) sb.push_back(8'h00);
    sb.push_back(8'hFF);
    expect_bytes(6, "wr_resp");
    check("wr_busy_end", {31'd0, busy}, 32'd0);
    check("wr_pulses", wr_pulses, 32'd512);
    check("wr_one_clock", {31'd0, wr_double}, 32'd0);
    errs = 0;
    for (int i = 0; i < 512; i++) if (mem[5*512+i] !== (8'(i) ^ 8'hA5)) errs++;
    check("wr_mem", errs, 32'd0);

    // Read back block 5
    send_cmd(6'd17, 32'd5);
    sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'hFE);
    for (int i = 0; i < 512; i++) sb.push_back(8'(i) ^ 8'hA5);
    sb.push_back(8'hFF); sb.push_back(8'hFF); sb.push_back(8'hFF);
    expect_bytes(519, "rd");

    // Abort a read with cs_n after 100 data bytes
    send_cmd(6'd17, 32'd5);
    sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'hFE);
    for (int i = 0; i < 100; i++) sb.push_back(8'(i) ^ 8'hA5);
    expect_bytes(104, "ab");
    cs_n = 1'b1;
    #100;
    check("ab_miso", {31'd0, miso}, 32'd1);
    cs_n = 1'b0;
    #100;
    send_cmd(6'd13, 32'd0);
    sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'hFF);
    expect_bytes(4, "ab_cmd13");
    check("ab_ready", {31'd0, card_ready}, 32'd1);

    // Write with a bad data token
    wr_snap = wr_pulses;
    send_cmd(6'd24, 32'd3);
    sb.push_back(8'hFF); sb.push_back(8'h00);
    expect_bytes(2, "tok_r1");
    xfer(8'hFC, d);
    #60;
    check("tok_busy", {31'd0, busy}, 32'd0);
    check("tok_no_write", wr_pulses, wr_snap);
    send_cmd(6'd13, 32'd0);
    sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'hFF);
    expect_bytes(4, "tok_cmd13");
    check("tok_no_write_end", wr_pulses, wr_snap);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_card_responder.md
# sd_card_responder

Synthesizable SPI-mode SD card model: the card side of the SD-over-SPI protocol driven by the team's SD host controller. It decodes 48-bit command frames on MOSI and answers on MISO with R1/R2/R7 responses, data tokens, data responses and busy signalling. Block data lives in an external byte-wide synchronous memory. It serves as the bench target for the host controller and as a drop-in card replacement in FPGA builds without a physical slot.

## Interface
- NUM_BLOCKS, 1024: number of 512-byte blocks. Must be a power of two, 2 or more.
- ACMD41_RETRIES, 2: number of ACMD41 replies of 0x01 before the model answers 0x00.
- BUSY_BYTES, 4: number of 0x00 busy bytes sent after a write data response.

Ports:
- clock  in  1  system clock; sck must be no faster than clock/4.
- reset  in  1  asynchronous, active-high.
- sck  in  1  SPI clock, mode 0; asynchronous to clock.
- cs_n  in  1  chip select, active low.
- mosi  in  1  host to card data.
- miso  out  1  card to host data.
- mem_addr  out  $clog2(NUM_BLOCKS)+9  byte address, {block, offset[8:0]}.
- mem_rd_data  in  8  memory read data; valid one clock after mem_addr.
- mem_wr_en  out  1  one-clock byte write strobe.
- mem_wr_data  out  8  write byte.
- card_ready  out  1  card has left the idle state.
- busy  out  1  high during CMD24 data phase and busy bytes.

## Operation
- Input sync: sck, cs_n and mosi each pass through a 2-FF synchronizer. Edge detect runs on the synchronized sck. MOSI is sampled on the sck rising edge. MISO updates on the falling edge. All shifts are MSB first.
- Framing:
  - Bit counter resets when cs_n is high.
  - While waiting for a command, whole bytes of 0xFF are ignored.
  - A command starts at a byte with bits[7:6]=01 and is 6 bytes long: {01, index[5:0]}, arg[31:0], {crc7, 1}.
- FSM: RxCmd, Ncr, TxResp, TxNac, TxToken, TxData, TxCrc, RxWaitToken, RxData, RxCrc, TxDataResp, TxBusy.
- Path after a full command: Ncr sends one 0xFF byte, then TxResp.
- Idle bit: the R1 idle bit (bit0) equals !card_ready.
- Command responses:
  - CMD0: R1 0x01. Clears card_ready and the ACMD41 count.
  - CMD8: R7 is 0x01 00 00 01 followed by arg[7:0] (arg 0x1AA gives 0x01 00 00 01 AA).
  - CMD59: R1 with idle bit only.
  - CMD55: R1 with idle bit only; sets app flag. The app flag clears after the next command.
  - ACMD41 (CMD41 with app flag): answers 0x01 for the first ACMD41_RETRIES calls, then 0x00 and sets card_ready.
  - CMD41 without app flag: illegal command (see last rule).
  - CMD16: arg 512 gives 0x00; any other arg gives 0x40.
  - CMD13: R2 is 0x00 0x00.
  - CMD17 and CMD24 take a block-number arg. arg >= NUM_BLOCKS gives R1 0x40 and no data phase.
  - CMD16, CMD17, CMD24 and CMD13 while !card_ready give 0x05.
  - Unknown index gives 0x04 | idle.
- CMD17 read: R1 0x00, TxNac (one 0xFF), TxToken 0xFE, 512 data bytes from memory at offsets 0..511, TxCrc sends 0xFF 0xFF, then back to RxCmd.
- CMD24 write:
  - R1 0x00, then RxWaitToken ignores 0xFF bytes until it sees 0xFE.
  - Any other token byte aborts to RxCmd with no write.
  - RxData: each received byte issues one mem_wr_en pulse at consecutive offsets.
  - RxCrc discards 2 bytes. TxDataResp sends 0x05, then BUSY_BYTES bytes of 0x00, then RxCmd.
- Bytes outside a response phase drive 0xFF.
- cs_n high at any time:
  - miso=1 and FSM returns to RxCmd.
  - card_ready, ACMD41 count and app flag are kept.
  - Writes already issued stand.

## Timing
- Reset values: miso=1, mem_addr=0, mem_wr_en=0, mem_wr_data=0, card_ready=0, busy=0, FSM=RxCmd.
- MISO for a byte is valid within 3 clocks of the falling sck edge that ends the previous byte.
- Read prefetch: mem_addr for byte n+1 is issued at byte n's load, so read data always arrives at least 2 clocks before it is needed.
- mem_wr_en pulses exactly one clock, 2–3 clocks after the rising sck edge of the byte's 8th bit.
- card_ready rises at the end of the ACMD41 response byte that returns 0x00.
- busy rises on token 0xFE detection and falls after the last busy byte.

## Configuration
- SD_RESPONDER_CRC_EN defined:
  - CRC7 (poly x^7+x^3+1) is computed over command bytes 0–4 and compared with byte5[7:1].
  - On mismatch the response is R1 0x08 | idle and the command is not executed.
  - CMD59 arg[0]=0 disables checking except for CMD0 and CMD8.
- Not defined: the CRC byte is ignored and CMD59 has no effect beyond its R1.

## Test plan
- Init: CMD0 -> 0x01; CMD8 arg 0x1AA -> 01 00 00 01 AA; CMD59 -> 0x01; (CMD55, ACMD41 0x40000000) ×3 -> 0x01, 0x01, 0x00; card_ready=1; CMD16 512 -> 0x00.
- Write then read: CMD24 block 5 with bytes i^0xA5 -> 0x05 then 4×0x00; CMD17 block 5 -> 0x00, 0xFF, 0xFE, same 512 bytes, FF FF.
- Before init: CMD17 -> 0x05, no data token; CMD13 after init -> 00 00; CMD17 block NUM_BLOCKS -> 0x40.
- Abort: cs_n high after 100 data bytes of a CMD17 -> miso=1; next CMD13 -> 00 00 with card_ready still 1.
- CMD24 with bad token 0xFC -> no mem_wr_en pulses, busy falls, next command answered normally.
- With SD_RESPONDER_CRC_EN: CMD0 with CRC byte 0x00 -> 0x09; with correct CRC byte 0x95 -> 0x01.
